countdown_timer: RTL

- Loadable down-counting timer; the count-down counterpart to the team's up-counters.
- Software or an FSM loads a terminal value and starts it. The timer decrements while enabled and signals expiry.
- One-shot mode: expiry is held until acknowledged. Periodic mode: the timer auto-reloads and pulses a tick on each expiry.
- Used for timeouts and rate generation in the accelerator control path.

---
 rtl/countdown_timer_pkg.sv | 13 +
 rtl/countdown_timer_if.sv | 29 ++
 rtl/countdown_timer_expiry_event_counter.sv | 25 ++
 rtl/countdown_timer.sv | 99 +++++++++
 4 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and default widths.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    localparam int DEF_NBITS = 32;
    localparam int DEF_EBITS = 16;

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle between a timer user (master) and the countdown timer (slave).
interface countdown_timer_if #(
    parameter int p_nbits = countdown_timer_pkg::DEF_NBITS,
    parameter int p_ebits = countdown_timer_pkg::DEF_EBITS
) ();

    logic [p_nbits-1:0] load_val;
    logic               start;
    logic               periodic;
    logic               cnten;
    logic               abort;
    logic               done_ack;
    logic               busy;
    logic               done;
    logic               tick;
    logic [p_nbits-1:0] remaining;
    logic [p_ebits-1:0] expire_cnt;

    modport master (
        output load_val, start, periodic, cnten, abort, done_ack,
        input  busy, done, tick, remaining, expire_cnt
    );

    modport slave (
        input  load_val, start, periodic, cnten, abort, done_ack,
        output busy, done, tick, remaining, expire_cnt
    );

endinterface

// File: rtl/countdown_timer_expiry_event_counter.sv
// Wrap-around event counter: increments once per expire strobe, cleared by synchronous reset.
module countdown_timer_expiry_event_counter
    import countdown_timer_pkg::*;
#(
    parameter int p_ebits = DEF_EBITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_expire,
    output logic [p_ebits-1:0] o_count
);

    logic [p_ebits-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_expire) begin
            r_count <= r_count + p_ebits'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counting timer with one-shot (held done) and periodic (auto-reload, tick) modes.
//
//  state      | meaning
//  ST_IDLE    | stopped; cnten ignored, remaining holds
//  ST_RUN     | counting down while cnten=1; busy=1
//  ST_EXPIRED | one-shot expiry held; done=1 until done_ack
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int p_nbits = DEF_NBITS,
    parameter int p_ebits = DEF_EBITS
) (
    input logic              clk,
    input logic              reset,
    countdown_timer_if.slave bus
);

    localparam logic [p_nbits-1:0] ONE = p_nbits'(1);

    state_t             r_state;
    logic [p_nbits-1:0] r_remaining;
    logic [p_nbits-1:0] r_reload;
    logic               r_mode;
    logic               r_tick;

    logic               w_load_zero;
    logic               w_terminal;
    logic               w_expire;
    logic [p_ebits-1:0] w_expire_cnt;

    assign w_load_zero = (bus.load_val == '0);
    assign w_terminal  = (r_remaining <= ONE);

    // A zero-length start is an expiry in either mode, even though periodic never enters RUN.
    assign w_expire = !reset && !bus.abort &&
                      (bus.start ? w_load_zero
                                 : (r_state == ST_RUN && bus.cnten && w_terminal));

    always_ff @(posedge clk) begin
        r_tick <= 1'b0;
        if (reset) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_reload    <= '0;
            r_mode      <= 1'b0;
        end else if (bus.abort) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
        end else if (bus.start) begin
            r_reload <= bus.load_val;
            r_mode   <= bus.periodic;
            if (!w_load_zero) begin
                r_remaining <= bus.load_val;
                r_state     <= ST_RUN;
            end else begin
                r_remaining <= '0;
                r_state     <= bus.periodic ? ST_IDLE : ST_EXPIRED;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (bus.cnten) begin
                        if (!w_terminal) begin
                            r_remaining <= r_remaining - ONE;
                        end else if (r_mode) begin
                            r_remaining <= r_reload;
                            r_tick      <= 1'b1;
                        end else begin
                            r_remaining <= '0;
                            r_state     <= ST_EXPIRED;
                        end
                    end
                end
                ST_EXPIRED: begin
                    if (bus.done_ack) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    countdown_timer_expiry_event_counter #(
        .p_ebits (p_ebits)
    ) u_expiry_cnt (
        .clk      (clk),
        .reset    (reset),
        .i_expire (w_expire),
        .o_count  (w_expire_cnt)
    );

    assign bus.busy       = (r_state == ST_RUN);
    assign bus.done       = (r_state == ST_EXPIRED);
    assign bus.tick       = r_tick;
    assign bus.remaining  = r_remaining;
    assign bus.expire_cnt = w_expire_cnt;

endmodule
